joy_db15_adapter: RTL and testbench

JOY_DB15_ADAPTER -- requirements
Module: joy_db15_adapter

---
 rtl/joy_db15_pkg.sv | 30 +++
 rtl/joy_db15_pin_sync.sv | 31 +++
 rtl/joy_db15_adapter.sv | 90 +++++++++
 tb/tb_joy_db15_adapter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/joy_db15_pkg.sv
// Shared definitions for the DB15 joystick serial link, used by both the
// adapter and the host-side receiver.
package joy_db15_pkg;

  localparam int CHAIN_BITS = 32;
  localparam int BIT_CNT_W  = 6;

  // Button layout within a 16-bit player word: LS FEDCBAUDLR (bit0 = R)
  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_UP     = 3;
  localparam int BTN_A      = 4;
  localparam int BTN_B      = 5;
  localparam int BTN_C      = 6;
  localparam int BTN_D      = 7;
  localparam int BTN_E      = 8;
  localparam int BTN_F      = 9;
  localparam int BTN_START  = 10;
  localparam int BTN_L      = 11;

  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

  // Wire-level image of both players: active-low, player 1 shifted out first.
  function automatic logic [CHAIN_BITS-1:0] chain_word(input logic [15:0] j1,
                                                       input logic [15:0] j2);
    return ~{j1, j2};
  endfunction

endpackage

// File: rtl/joy_db15_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin, followed by a single
// edge-detect flop producing a one-cycle pulse on the selected edge.
module pin_sync #(
  parameter int STAGES      = 2,
  parameter bit DETECT_RISE = 1'b1
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic edge_pulse
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Reset to the idle-high level so releasing reset never fakes a falling edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level      = sync_q[STAGES-1];
  assign edge_pulse = DETECT_RISE ? (level & ~prev_q) : (~level & prev_q);

endmodule

// File: rtl/joy_db15_adapter.sv
// Presents two 16-button pads to a DB15 host as a 32-bit active-low shift
// chain clocked by the host's JOY_CLK/JOY_LOAD pins.
module joy_db15_adapter
  import joy_db15_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [15:0]          joystick1,
  input  logic [15:0]          joystick2,
  input  logic                 JOY_CLK,
  input  logic                 JOY_LOAD,
  output logic                 JOY_DATA,
  output logic                 frame_done,
  output logic                 link_active,
  output logic [BIT_CNT_W-1:0] bit_cnt
);

  localparam int       IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);
  localparam bit_cnt_t FULL_CNT = BIT_CNT_W'(CHAIN_BITS);
  localparam bit_cnt_t LAST_CNT = BIT_CNT_W'(CHAIN_BITS - 1);

  logic                  clk_level;
  logic                  clk_rise;
  logic                  load_level;
  logic                  load_fall;
  logic [CHAIN_BITS-1:0] sr;
  logic [IDLE_W-1:0]     idle_cnt;

  pin_sync #(.STAGES(SYNC_STAGES), .DETECT_RISE(1'b1)) u_clk_sync (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .pin        (JOY_CLK),
    .level      (clk_level),
    .edge_pulse (clk_rise)
  );

  pin_sync #(.STAGES(SYNC_STAGES), .DETECT_RISE(1'b0)) u_load_sync (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .pin        (JOY_LOAD),
    .level      (load_level),
    .edge_pulse (load_fall)
  );

  // Load is level-sensitive and dominates any coincident shift edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sr         <= '1;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!load_level) begin
        sr      <= chain_word(joystick1, joystick2);
        bit_cnt <= '0;
      end else if (clk_rise && clk_level) begin
        sr <= {sr[CHAIN_BITS-2:0], 1'b1};
        if (bit_cnt != FULL_CNT) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
        if (bit_cnt == LAST_CNT) begin
          frame_done <= 1'b1;
        end
      end
    end
  end

  // Host watchdog: each load edge restarts the idle window.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      idle_cnt    <= '0;
      link_active <= 1'b0;
    end else if (load_fall) begin
      idle_cnt    <= '0;
      link_active <= 1'b1;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + 1'b1;
      if (idle_cnt == IDLE_MAX - 1'b1) begin
        link_active <= 1'b0;
      end
    end
  end

  assign JOY_DATA = sr[CHAIN_BITS-1];

endmodule

// File: tb/tb_joy_db15_adapter.sv
// Scoreboard bench: every host clock pulse queues the bit the host should see,
// and a monitor on the JOY_CLK pin pops and compares it.
module tb_joy_db15_adapter;

  localparam int SYNC    = 2;
  localparam int TIMEOUT = 100;

  typedef struct {
    logic       data;
    logic [5:0] cnt;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        JOY_CLK;
  logic        JOY_LOAD;
  logic        JOY_DATA;
  logic        frame_done;
  logic        link_active;
  logic [5:0]  bit_cnt;

  exp_t        exp_q[$];
  int          checks     = 0;
  int          errors     = 0;
  int          frame_seen = 0;
  int          frames_exp = 0;
  logic [31:0] model_word = '1;
  int          model_k    = 0;

  joy_db15_adapter #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .joystick1   (joystick1),
    .joystick2   (joystick2),
    .JOY_CLK     (JOY_CLK),
    .JOY_LOAD    (JOY_LOAD),
    .JOY_DATA    (JOY_DATA),
    .frame_done  (frame_done),
    .link_active (link_active),
    .bit_cnt     (bit_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] bench hung");
  end

  function automatic logic model_bit();
    return (model_k < 32) ? model_word[31 - model_k] : 1'b1;
  endfunction

  function automatic logic [5:0] model_cnt();
    return (model_k < 32) ? 6'(model_k) : 6'd32;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // The host samples JOY_DATA right as it raises JOY_CLK.
  initial begin
    forever begin
      @(posedge JOY_CLK);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_underflow: got clock edge expected none");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (JOY_DATA !== e.data || bit_cnt !== e.cnt) begin
          errors++;
          $display("[TB] FAIL sb_bit: got data=%0b cnt=%0d expected data=%0b cnt=%0d",
                   JOY_DATA, bit_cnt, e.data, e.cnt);
        end
      end
    end
  end

  initial begin
    logic fd_prev;
    fd_prev = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (frame_done) begin
        frame_seen++;
        if (fd_prev) begin
          errors++;
          $display("[TB] FAIL frame_width: got 2+ cycles expected 1");
        end
      end
      fd_prev = frame_done;
    end
  end

  task automatic pulse_clk();
    exp_q.push_back('{model_bit(), model_cnt()});
    JOY_CLK = 1'b1;
    wait_cycles(5);
    JOY_CLK = 1'b0;
    wait_cycles(5);
    if (JOY_LOAD) begin
      model_k++;
      if (model_k == 32) frames_exp++;
    end
  endtask

  // Load a frame (with a transparent-load update and an ignored clock), then shift nclk bits.
  task automatic applyStimulus(input logic [15:0] j1, input logic [15:0] j2, input int nclk);
    joystick1 = 16'($urandom);
    joystick2 = 16'($urandom);
    JOY_LOAD  = 1'b0;
    wait_cycles(6);
    joystick1  = j1;
    joystick2  = j2;
    model_word = ~{j1, j2};
    model_k    = 0;
    wait_cycles(4);
    checkOutput("load_data", 32'(JOY_DATA), 32'(model_word[31]));
    checkOutput("load_link", 32'(link_active), 32'd1);
    pulse_clk();
    checkOutput("load_cnt", 32'(bit_cnt), 32'd0);
    JOY_LOAD = 1'b1;
    wait_cycles(5);
    for (int i = 0; i < nclk; i++) pulse_clk();
    checkOutput("frame_cnt", 32'(bit_cnt), 32'(model_cnt()));
    checkOutput("frame_data", 32'(JOY_DATA), 32'(model_bit()));
    checkOutput("frame_done_count", 32'(frame_seen), 32'(frames_exp));
  endtask

  initial begin
    int n_high;
    reset     = 1'b1;
    JOY_CLK   = 1'b0;
    JOY_LOAD  = 1'b1;
    joystick1 = '0;
    joystick2 = '0;
    wait_cycles(4);
    checkOutput("rst_data", 32'(JOY_DATA), 32'd1);
    checkOutput("rst_cnt", 32'(bit_cnt), 32'd0);
    checkOutput("rst_link", 32'(link_active), 32'd0);
    checkOutput("rst_frame", 32'(frame_done), 32'd0);
    reset = 1'b0;
    wait_cycles(5);

    applyStimulus(16'h0001, 16'h0000, 32);
    applyStimulus(16'hFFFF, 16'hFFFF, 40);
    applyStimulus(16'($urandom), 16'($urandom), 10);
    applyStimulus(16'h8000, 16'h0000, 0);

    // Coincident clock rise and load fall mid-frame: the load must win.
    applyStimulus(16'h1234, 16'h5678, 7);
    joystick1 = 16'h8421;
    joystick2 = 16'h0F0F;
    exp_q.push_back('{model_bit(), model_cnt()});
    JOY_CLK  = 1'b1;
    JOY_LOAD = 1'b0;
    model_word = ~{16'h8421, 16'h0F0F};
    model_k    = 0;
    wait_cycles(5);
    checkOutput("coinc_cnt", 32'(bit_cnt), 32'd0);
    checkOutput("coinc_data", 32'(JOY_DATA), 32'(model_word[31]));
    JOY_CLK = 1'b0;
    wait_cycles(5);
    JOY_LOAD = 1'b1;
    wait_cycles(5);
    checkOutput("coinc_hold", 32'(bit_cnt), 32'd0);
    pulse_clk();
    checkOutput("coinc_frames", 32'(frame_seen), 32'(frames_exp));

    for (int f = 0; f < 10; f++) begin
      applyStimulus(16'($urandom), 16'($urandom), int'($urandom_range(0, 40)));
    end

    // Idle timeout window measured from a single load edge.
    wait_cycles(150);
    checkOutput("link_idle", 32'(link_active), 32'd0);
    JOY_LOAD = 1'b0;
    n_high = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_sys);
      if (i == 6) JOY_LOAD = 1'b1;
      if (link_active) n_high++;
    end
    checkOutput("link_window", 32'(n_high), 32'(TIMEOUT));
    checkOutput("link_expired", 32'(link_active), 32'd0);
    applyStimulus(16'h00F0, 16'h0F00, 3);

    // Reset after 20 shifts discards the frame.
    applyStimulus(16'($urandom), 16'($urandom), 20);
    reset = 1'b1;
    wait_cycles(1);
    checkOutput("midrst_data", 32'(JOY_DATA), 32'd1);
    checkOutput("midrst_cnt", 32'(bit_cnt), 32'd0);
    checkOutput("midrst_link", 32'(link_active), 32'd0);
    reset = 1'b0;
    model_word = '1;
    model_k    = 0;
    wait_cycles(5);
    for (int i = 0; i < 12; i++) pulse_clk();
    checkOutput("midrst_after_cnt", 32'(bit_cnt), 32'd12);
    checkOutput("midrst_frames", 32'(frame_seen), 32'(frames_exp));

    wait_cycles(10);
    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
